// File: rtl/shift_seq_ctrl_if.sv
// Purpose : request/response and shift-unit signal bundle for shift_seq_ctrl.
// Latency : none (wires only).
// Backpr. : req_valid/req_ready and rsp_valid/rsp_ready handshakes carried here.
//
// Modports:
//   slave  - the sequencer view: takes requests, drives the shift unit,
//            returns responses.
//   master - the surrounding view: ALU control path issuing requests and
//            consuming responses, plus the shift unit returning its result.
interface shift_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int AMT_WIDTH  = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_data;
  logic [AMT_WIDTH-1:0]  req_amt;
  logic                  req_dir;

  logic [DATA_WIDTH-1:0] su_in1;
  logic [DATA_WIDTH-1:0] su_in2;
  logic [1:0]            su_shift_fun;
  logic                  su_shift_en;
  logic [DATA_WIDTH-1:0] su_shift_out;
  logic                  su_shift_flag;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_data, req_amt, req_dir,
    input  su_shift_out, su_shift_flag,
    input  rsp_ready,
    output req_ready,
    output su_in1, su_in2, su_shift_fun, su_shift_en,
    output rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_data, req_amt, req_dir,
    output su_shift_out, su_shift_flag,
    output rsp_ready,
    input  req_ready,
    input  su_in1, su_in2, su_shift_fun, su_shift_en,
    input  rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Purpose : runs a multi-bit logical shift by stepping a one-bit shift unit.
// Latency : rsp_valid 2*min(amt,DATA_WIDTH)+1 cycles after request handshake.
// Backpr. : one operation at a time; req_ready low until response is taken.
//
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-low reset.
//   bus (slave)   - req_* request, su_* shift-unit drive/return, rsp_* response.
//   busy          - high whenever the controller is not idle.
//   steps_done    - number of shift steps performed (SHIFT_SEQ_EARLY_EXIT_EN only).
//
// Build option: define SHIFT_SEQ_EARLY_EXIT_EN to stop as soon as the shift
// unit returns zero (further steps cannot change a zero operand).
module shift_seq_ctrl #(
  parameter int         DATA_WIDTH = 16,
  parameter int         AMT_WIDTH  = 5,
  parameter logic [1:0] FUN_SHR    = 2'b00,
  parameter logic [1:0] FUN_SHL    = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_seq_ctrl_if.slave      bus,
  output logic                 busy
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  ,
  output logic [AMT_WIDTH:0]   steps_done
`endif
);

  // Step counter must hold both any request amount and the DATA_WIDTH clamp.
  localparam int DW_BITS = $clog2(DATA_WIDTH + 1);
  localparam int CNT_W   = (AMT_WIDTH > DW_BITS) ? AMT_WIDTH : DW_BITS;
  localparam logic [CNT_W-1:0] CLAMP = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [CNT_W-1:0]      cnt;
  logic                  dir_q;
  logic                  err_q;
  logic                  req_ready_q;
  logic                  su_en_q;
  logic                  rsp_valid_q;
  logic                  busy_q;

  logic [CNT_W-1:0]      amt_ext;
  logic [CNT_W-1:0]      amt_clamped;
  logic                  last_step;

  assign amt_ext     = CNT_W'(bus.req_amt);
  assign amt_clamped = (amt_ext > CLAMP) ? CLAMP : amt_ext;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  localparam int SD_W = AMT_WIDTH + 1;
  logic [SD_W-1:0] steps_q;
  assign steps_done = steps_q;
  // A zero result stays zero under any further logical shift.
  assign last_step  = (cnt == ONE) || (bus.su_shift_out == '0);
`else
  assign last_step  = (cnt == ONE);
`endif

  // acc and dir_q are registers, so every shift-unit and response output is
  // a register (or a constant-select of one) with no path from the inputs.
  assign bus.req_ready    = req_ready_q;
  assign bus.su_in1       = acc;
  assign bus.su_in2       = '0;
  assign bus.su_shift_fun = dir_q ? FUN_SHL : FUN_SHR;
  assign bus.su_shift_en  = su_en_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = acc;
  assign bus.rsp_err      = err_q;
  assign busy             = busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      su_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
      steps_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            acc         <= bus.req_data;
            dir_q       <= bus.req_dir;
            cnt         <= amt_clamped;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
            steps_q     <= '0;
`endif
            if (amt_clamped == '0) begin
              state       <= DONE;
              rsp_valid_q <= 1'b1;
            end else begin
              state   <= ISSUE;
              su_en_q <= 1'b1;
            end
          end
        end

        // Enable was raised on entry, so it is high for exactly this cycle.
        ISSUE: begin
          su_en_q <= 1'b0;
          state   <= WAIT;
        end

        // Shift unit registered its result on the ISSUE edge; take it now.
        WAIT: begin
          acc   <= bus.su_shift_out;
          cnt   <= cnt - ONE;
          err_q <= err_q | ~bus.su_shift_flag;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
          steps_q <= steps_q + SD_W'(1);
`endif
          if (last_step) begin
            state       <= DONE;
            rsp_valid_q <= 1'b1;
          end else begin
            state   <= ISSUE;
            su_en_q <= 1'b1;
          end
        end

        // req_ready stays low here, so a request presented alongside
        // rsp_ready is only taken in the following IDLE cycle.
        DONE: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
          su_en_q     <= 1'b0;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Purpose : directed checks of shift_seq_ctrl against hand-computed vectors.
// Latency : n/a (bench).
// Backpr. : exercises response stall with a pending request.
module tb_shift_seq_ctrl;

  logic clk;
  logic rst;
  logic busy;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  logic [5:0] steps_done;
`endif

  shift_seq_ctrl_if #(.DATA_WIDTH(16), .AMT_WIDTH(5)) bus ();

  shift_seq_ctrl #(
    .DATA_WIDTH(16),
    .AMT_WIDTH (5),
    .FUN_SHR   (2'b00),
    .FUN_SHL   (2'b01)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    ,
    .steps_done(steps_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-bit shift unit with registered output; fault_step selects the step
  // (0-based within an operation) that returns su_shift_flag low.
  int fault_step;
  int step_idx;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.su_shift_out  <= '0;
      bus.su_shift_flag <= 1'b0;
      step_idx          <= 0;
    end else if (bus.req_valid && bus.req_ready) begin
      step_idx <= 0;
    end else if (bus.su_shift_en) begin
      bus.su_shift_out  <= (bus.su_shift_fun == 2'b01) ? (bus.su_in1 << 1)
                                                       : (bus.su_in1 >> 1);
      bus.su_shift_flag <= (step_idx != fault_step);
      step_idx          <= step_idx + 1;
    end
  end

  typedef struct {
    logic [15:0] data;
    logic [4:0]  amt;
    logic        dir;
    int          fault;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[12];
  int   n_vec;
  int   n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},    32'(bus.req_ready),    32'd1);
    check({tag, " su_shift_en"},  32'(bus.su_shift_en),  32'd0);
    check({tag, " su_in1"},       32'(bus.su_in1),       32'd0);
    check({tag, " su_in2"},       32'(bus.su_in2),       32'd0);
    check({tag, " su_shift_fun"}, 32'(bus.su_shift_fun), 32'd0);
    check({tag, " rsp_valid"},    32'(bus.rsp_valid),    32'd0);
    check({tag, " rsp_data"},     32'(bus.rsp_data),     32'd0);
    check({tag, " rsp_err"},      32'(bus.rsp_err),      32'd0);
    check({tag, " busy"},         32'(busy),             32'd0);
  endtask

  // Called and returns at a negedge. Latency counts rising edges after the
  // handshake edge until rsp_valid is seen.
  task automatic run_op(input vec_t v, input string tag);
    int  t;
    int  lat;
    int  pulses;
    logic prev_en;
    fault_step    = v.fault;
    bus.req_data  = v.data;
    bus.req_amt   = v.amt;
    bus.req_dir   = v.dir;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    t = 0;
    while (!bus.req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, " accept"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    // Scramble request fields: they must already have been captured.
    bus.req_valid = 1'b0;
    bus.req_data  = ~v.data;
    bus.req_amt   = ~v.amt;
    bus.req_dir   = ~v.dir;
    lat     = 1;
    pulses  = 0;
    prev_en = 1'b0;
    while (!bus.rsp_valid && lat < 60) begin
      if (bus.su_shift_en) begin
        pulses++;
        check({tag, " pulse spacing"}, 32'(prev_en), 32'd0);
      end
      prev_en = bus.su_shift_en;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"},  32'(lat),          32'(v.exp_lat));
    check({tag, " rsp_data"}, 32'(bus.rsp_data), 32'(v.exp_data));
    check({tag, " rsp_err"},  32'(bus.rsp_err),  32'(v.exp_err));
    check({tag, " pulses"},   32'(pulses),       32'(v.exp_pulses));
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    check({tag, " steps_done"}, 32'(steps_done), 32'(v.exp_pulses));
`endif
    @(negedge clk);
    check({tag, " idle after rsp"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt_valid;
    int cnt_busy;
    n_vec = 0;
    n_bad = 0;
    fault_step = -1;

    //             data     amt    dir  flt  exp       err   lat  pulses
    vecs[0]  = '{16'h0026, 5'd1,  1'b0, -1, 16'h0013, 1'b0, 3,  1};
    vecs[1]  = '{16'h0026, 5'd1,  1'b1, -1, 16'h004C, 1'b0, 3,  1};
    vecs[2]  = '{16'h8001, 5'd4,  1'b1, -1, 16'h0010, 1'b0, 9,  4};
    vecs[3]  = '{16'h1234, 5'd0,  1'b0, -1, 16'h1234, 1'b0, 1,  0};
    vecs[4]  = '{16'hFFFF, 5'd20, 1'b0, -1, 16'h0000, 1'b0, 33, 16};
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    vecs[5]  = '{16'h0003, 5'd20, 1'b0, -1, 16'h0000, 1'b0, 5,  2};
    vecs[11] = '{16'h0000, 5'd5,  1'b1, -1, 16'h0000, 1'b0, 3,  1};
`else
    vecs[5]  = '{16'h0003, 5'd20, 1'b0, -1, 16'h0000, 1'b0, 33, 16};
    vecs[11] = '{16'h0000, 5'd5,  1'b1, -1, 16'h0000, 1'b0, 11, 5};
`endif
    vecs[6]  = '{16'h0001, 5'd16, 1'b1, -1, 16'h0000, 1'b0, 33, 16};
    vecs[7]  = '{16'hA5A5, 5'd31, 1'b1, -1, 16'h0000, 1'b0, 33, 16};
    vecs[8]  = '{16'h8000, 5'd15, 1'b0, -1, 16'h0001, 1'b0, 31, 15};
    vecs[9]  = '{16'h4001, 5'd2,  1'b1, -1, 16'h0004, 1'b0, 5,  2};
    vecs[10] = '{16'h00F0, 5'd3,  1'b0, 1,  16'h001E, 1'b1, 7,  3};

    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.req_amt   = '0;
    bus.req_dir   = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Response stall with a new request already waiting.
    fault_step    = -1;
    bus.req_data  = 16'h0026;
    bus.req_amt   = 5'd1;
    bus.req_dir   = 1'b0;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("stall rsp_valid", 32'(bus.rsp_valid), 32'd1);
    bus.req_data  = 16'h0100;
    bus.req_amt   = 5'd1;
    bus.req_dir   = 1'b1;
    bus.req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("stall%0d rsp_data", c),  32'(bus.rsp_data),  32'h13);
      check($sformatf("stall%0d req_ready", c), 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("release req_ready", 32'(bus.req_ready), 32'd1);
    check("release rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("release busy",      32'(busy),          32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("late accept busy",  32'(busy),             32'd1);
    check("late accept en",    32'(bus.su_shift_en),  32'd1);
    check("late accept in1",   32'(bus.su_in1),       32'h0100);
    check("late accept fun",   32'(bus.su_shift_fun), 32'd1);
    repeat (2) @(negedge clk);
    check("late rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("late rsp_data",  32'(bus.rsp_data),  32'h0200);
    @(negedge clk);

    // Reset during WAIT of an amt=8 operation.
    bus.req_data  = 16'h00FF;
    bus.req_amt   = 5'd8;
    bus.req_dir   = 1'b1;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midop busy",  32'(busy),            32'd1);
    check("midop wait",  32'(bus.su_shift_en), 32'd0);
    rst = 1'b0;
    #1;
    check_reset_outputs("async reset");
    @(negedge clk);
    rst = 1'b1;
    cnt_valid = 0;
    cnt_busy  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) cnt_valid++;
      if (busy) cnt_busy++;
    end
    check("abandoned rsp_valid cycles", 32'(cnt_valid), 32'd0);
    check("abandoned busy cycles",      32'(cnt_busy),  32'd0);

    run_op(vecs[10], "post-reset fault");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
